// File: rtl/im_bootloader.sv
// im_bootloader: receives a length-prefixed byte stream and writes it into
// instruction memory one 32-bit word at a time, keeping the core held off
// while the load is in progress. An optional trailing checksum byte is checked.
module im_bootloader #(
    parameter int CHK_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        we,
    output logic [12:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        hold_cpu,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam int MAX_WORDS = 8192;

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q;
    logic [13:0] len_q;
    logic [13:0] words_q;
    logic [1:0]  bcnt_q;
    logic [23:0] asm_q;
    logic [7:0]  sum_q;
    logic        we_q;
    logic [12:0] waddr_q;
    logic [31:0] wdata_q;

    logic [15:0] len_n;
    logic        last_word;

    // Full 16-bit length as it becomes known on the LEN_HI byte
    assign len_n     = {rx_data, len_lo_q};
    // The word now being completed is the final one of the image
    assign last_word = (words_q + 14'd1 == len_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; bytes are only consumed while a load is active
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (boot_start) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (rx_valid) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (rx_valid) begin
                    if (len_n == 16'd0 || len_n > 16'(MAX_WORDS)) state_d = S_ERR;
                    else                                           state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_valid && bcnt_q == 2'd3 && last_word)
                    state_d = (CHK_EN != 0) ? S_CHK : S_DONE;
            end
            S_CHK: begin
                if (rx_valid) state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from state; done/err stick until the next boot_start
    always_comb begin
        busy     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                   (state_q == S_DATA)   || (state_q == S_CHK);
        hold_cpu = busy;
        done     = (state_q == S_DONE);
        err      = (state_q == S_ERR);
    end

    // Datapath: length capture, word assembly, checksum and the write port.
    // The write fires the cycle after the 4th byte; waddr advances only once
    // that cycle is over, so address and data are steady for the whole pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo_q <= '0;
            len_q    <= '0;
            words_q  <= '0;
            bcnt_q   <= '0;
            asm_q    <= '0;
            sum_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            we_q <= 1'b0;
            if (we_q) waddr_q <= waddr_q + 13'd1;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    // Later assignment wins over a same-cycle address bump
                    if (boot_start) begin
                        waddr_q <= '0;
                        sum_q   <= '0;
                        bcnt_q  <= '0;
                        words_q <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (rx_valid) len_lo_q <= rx_data;
                end
                S_LEN_HI: begin
                    if (rx_valid) len_q <= len_n[13:0];
                end
                S_DATA: begin
                    if (rx_valid) begin
                        sum_q  <= sum_q + rx_data;
                        bcnt_q <= bcnt_q + 2'd1;
                        case (bcnt_q)
                            2'd0: asm_q[7:0]   <= rx_data;
                            2'd1: asm_q[15:8]  <= rx_data;
                            2'd2: asm_q[23:16] <= rx_data;
                            default: begin
                                we_q    <= 1'b1;
                                wdata_q <= {rx_data, asm_q};
                                words_q <= words_q + 14'd1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_im_bootloader.sv
// Self-checking bench for im_bootloader: directed scenarios plus random loads,
// each compared against a stream-level reference model of the expected writes.
module tb_im_bootloader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst, boot_start, rx_valid;
    logic [7:0]  rx_data;
    logic        we, busy, hold_cpu, done, err;
    logic [12:0] waddr;
    logic [31:0] wdata;

    int errors = 0;
    int checks = 0;

    logic [44:0] wq[$];
    logic [44:0] exp_q[$];
    logic        exp_done, exp_err;
    int          dbl_we = 0;
    logic        we_prev = 1'b0;

    always #5 clk = ~clk;

    im_bootloader #(.CHK_EN(1)) dut (
        .clk(clk), .rst(rst), .boot_start(boot_start), .rx_valid(rx_valid),
        .rx_data(rx_data), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .hold_cpu(hold_cpu), .done(done), .err(err)
    );

    // Write monitor: capture every memory write mid-cycle
    always @(negedge clk) begin
        if (we === 1'b1) wq.push_back({waddr, wdata});
        if (we === 1'b1 && we_prev === 1'b1) dbl_we++;
        we_prev = we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: what the memory should see and how the load should end
    task automatic model(input bq_t s);
        int n;
        logic [7:0] sum;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'(s[1]) * 256 + int'(s[0]);
        if (n == 0 || n > 8192) begin
            exp_err = 1'b1;
            return;
        end
        sum = 8'd0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({13'(i), s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
            for (int k = 0; k < 4; k++) sum = sum + s[2+4*i+k];
        end
        if (s[2+4*n] == sum) exp_done = 1'b1;
        else                 exp_err  = 1'b1;
    endtask

    task automatic send_stream(input bq_t s, input int gapmax, input int boot_at);
        for (int i = 0; i < s.size(); i++) begin
            if (i == boot_at) begin
                boot_start = 1'b1;
                tick();
                boot_start = 1'b0;
            end
            rx_valid = 1'b1;
            rx_data  = s[i];
            tick();
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            if (gapmax > 0) repeat ($urandom_range(gapmax, 0)) tick();
        end
    endtask

    task automatic check_result(input string tag);
        int bad = 0;
        chk({tag, " nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) if (i >= wq.size() || wq[i] !== exp_q[i]) bad++;
        chk({tag, " write contents"}, 64'(bad), 64'd0);
        chk({tag, " done"}, 64'(done), 64'(exp_done));
        chk({tag, " err"}, 64'(err), 64'(exp_err));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " hold_cpu"}, 64'(hold_cpu), 64'd0);
        chk({tag, " single-cycle we"}, 64'(dbl_we), 64'd0);
    endtask

    // Full load: stray bytes first (must be ignored), boot pulse, stream, check
    task automatic run_load(input bq_t s, input int gapmax, input int boot_at, input string tag);
        wq.delete();
        dbl_we = 0;
        model(s);
        repeat (2) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            tick();
            rx_valid = 1'b0;
        end
        boot_start = 1'b1;
        tick();
        boot_start = 1'b0;
        send_stream(s, gapmax, boot_at);
        repeat (3) tick();
        check_result(tag);
    endtask

    initial begin
        bq_t s;
        logic [7:0] sum;
        logic [44:0] w1;
        int n;

        rst = 1'b1; boot_start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        repeat (3) tick();
        chk("reset we", 64'(we), 64'd0);
        chk("reset waddr", 64'(waddr), 64'd0);
        chk("reset wdata", 64'(wdata), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset hold_cpu", 64'(hold_cpu), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        rst = 1'b0;
        tick();

        // Two words; checksum byte is the mod-256 sum of the eight data bytes (0x4C)
        s = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        run_load(s, 1, -1, "two-word good");
        chk("two-word w0", wq.size() > 0 ? 64'(wq[0]) : 'x, 64'({13'd0, 32'h12345678}));
        chk("two-word w1", wq.size() > 1 ? 64'(wq[1]) : 'x, 64'({13'd1, 32'hDEADBEEF}));
        chk("two-word done", 64'(done), 64'd1);

        // Same stream, wrong checksum
        s[10] = 8'h19;
        run_load(s, 0, -1, "bad checksum");
        chk("bad checksum err", 64'(err), 64'd1);
        chk("bad checksum done", 64'(done), 64'd0);

        // Illegal lengths
        s = {8'h00, 8'h00};
        run_load(s, 0, -1, "len 0");
        chk("len 0 err", 64'(err), 64'd1);
        s = {8'h01, 8'h20};
        run_load(s, 0, -1, "len 0x2001");
        chk("len 0x2001 err", 64'(err), 64'd1);

        // boot_start in the middle of word 0 must change nothing
        s = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        run_load(s, 0, 4, "mid-data boot");
        chk("mid-data boot done", 64'(done), 64'd1);

        // Reset after two of three words
        wq.delete();
        boot_start = 1'b1; tick(); boot_start = 1'b0;
        s = {8'h03, 8'h00};
        for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
        w1 = {13'd1, s[9], s[8], s[7], s[6]};
        send_stream(s, 0, -1);
        rst = 1'b1;
        tick();
        chk("abort we", 64'(we), 64'd0);
        chk("abort waddr", 64'(waddr), 64'd0);
        chk("abort wdata", 64'(wdata), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hold_cpu", 64'(hold_cpu), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort err", 64'(err), 64'd0);
        rst = 1'b0;
        s.delete();
        for (int i = 0; i < 9; i++) s.push_back(8'($urandom));
        send_stream(s, 0, -1);
        repeat (2) tick();
        chk("abort nwrites", 64'(wq.size()), 64'd2);
        chk("abort w1", wq.size() > 1 ? 64'(wq[1]) : 'x, 64'(w1));
        chk("abort idle busy", 64'(busy), 64'd0);

        // Random loads
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(6, 1);
            s = {8'(n), 8'h00};
            sum = 8'd0;
            for (int i = 0; i < 4 * n; i++) begin
                s.push_back(8'($urandom));
                sum = sum + s[s.size()-1];
            end
            s.push_back(($urandom_range(3, 0) == 0) ? (sum ^ 8'h5A) : sum);
            run_load(s, 2, -1, $sformatf("random %0d", t));
        end

        // Maximum image, one byte every cycle
        s = {8'h00, 8'h20};
        sum = 8'd0;
        for (int i = 0; i < 4 * 8192; i++) begin
            s.push_back(8'($urandom));
            sum = sum + s[s.size()-1];
        end
        s.push_back(sum);
        run_load(s, 0, -1, "max image");
        chk("max image last waddr", wq.size() > 0 ? 64'(wq[wq.size()-1][44:32]) : 'x, 64'h1FFF);
        chk("max image waddr wrap", 64'(waddr), 64'd0);
        chk("max image done", 64'(done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
